gamecube_responder: RTL and testbench
=====================================

// Module: gamecube_responder
// PURPOSE
//  Device end of the GameCube joybus link: emulates a controller so the board can be polled by a console or host.
//  Decodes console commands from the single open-drain line and replies with button/stick state, bit-serial, MSB first.
//  Drives only an open-drain enable; the top level wires data = data_oe ? 1'b0 : 1'bz and data_in = data (pull-up on pin).
// PARAMETERS
//  CLKS_PER_US    100  clk cycles per microsecond (100 MHz)
//  RESP_DELAY_US  4    gap from command stop-bit release to first reply falling edge; must be within 2..20 us
//  TIMEOUT_US     8    line stuck high or low this long mid-command -> abort
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  synchronous reset, active-low
//  data_in      in   1  raw joybus line (asynchronous)
//  data_oe      out  1  1 = pull line low, 0 = release
//  btn_a, btn_b, btn_x, btn_y, btn_start  in  1 each  face buttons, 1 = pressed
//  btn_l, btn_r, btn_z                    in  1 each  shoulder/Z digital
//  d_up, d_down, d_right, d_left          in  1 each  D-pad
//  joy_x, joy_y, c_x, c_y, trig_l, trig_r in  8 each  analog values
//  cmd_valid    out  1  one-cycle pulse: a legal command fully received
//  cmd_byte     out  8  opcode of last legal command (held)
//  rumble       out  1  LSB of byte 2 of last 0x40 poll (held)
//  busy         out  1  1 in any state except S_IDLE
//  rx_err       out  1  one-cycle pulse: unknown opcode or timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE, line released. A reset mid-reply releases data_oe on the reset edge.
//  - data_in passes through a 2-flop synchronizer; all timing below uses the synchronized line.
//  - Symbol decode: each low pulse is one symbol; low time < 2*CLKS_PER_US -> '1', otherwise '0'.
//  - Command framing: the first 8 symbols form the opcode.
//    0x40 -> 16 more data bits, then the stop symbol (25 symbols total).
//    0x00, 0x41, 0xFF -> stop symbol only (9 symbols). Any other opcode -> rx_err, wait for line idle TIMEOUT_US, S_IDLE.
//  - Command accepted on the rising edge that ends the stop symbol: cmd_valid pulses, cmd_byte updates, rumble updates on 0x40.
//  - States: S_IDLE -(fall)-> S_RX -(stop rise)-> S_GAP -(RESP_DELAY_US*CLKS_PER_US cycles)-> S_TX -(last bit)-> S_STOP -> S_IDLE.
//  - S_RX: line low or high for TIMEOUT_US*CLKS_PER_US cycles -> rx_err, S_IDLE, no reply.
//  - Reply bit period is 4*CLKS_PER_US cycles.
//    '1' = low for CLKS_PER_US, then released. '0' = low for 3*CLKS_PER_US, then released.
//    Stop = low for CLKS_PER_US, then released; line stays released thereafter.
//  - Reply content, latched in one cycle on entry to S_TX so there is no tearing:
//    0x00 / 0xFF -> 24 bits 0x09_00_00.
//    0x40 -> 64 bits: {3'b0,start,y,x,b,a}, {1'b1,l,r,z,up,down,right,left}, joy_x, joy_y, c_x, c_y, trig_l, trig_r.
//    0x41 -> the same 64 bits followed by 16'h0000 (80 bits).
//  - In S_GAP, S_TX and S_STOP, data_in is ignored (own echo). A falling edge arriving in S_GAP is ignored.
//  - Counter widths: bit counter 7 bits (max 80). Timing counter sized for max(4, TIMEOUT_US)*CLKS_PER_US.
// STRUCTURE
//  - gc_pkg:
//    opcodes GC_CMD_ID=8'h00, GC_CMD_POLL=8'h40, GC_CMD_ORIGIN=8'h41, GC_CMD_RESET=8'hFF;
//    ID word 24'h090000; state encodings; reply-length constants.
//  - Sub-module gc_line_sync: 2-flop synchronizer plus registered fall/rise pulses. Shared with the host-side block.
//  - Top FSM, shift register and timers live in gamecube_responder.
// TESTING
//  1. Console sends 0x400300 + stop, all inputs 0 -> reply 64 bits 0x00800000_00000000 + stop; rumble=0; cmd_valid once.
//  2. 0x400301, btn_a=1, joy_x=8'h80, trig_r=8'hFF -> first byte 0x01, byte2=0x80, byte7=0xFF; rumble=1.
//  3. Cmd 0x00 + stop -> first reply fall exactly RESP_DELAY_US*CLKS_PER_US (+sync) cycles after stop rise; bits 0x090000 + stop.
//  4. Cmd 0x41 -> 80-bit reply, last 16 bits zero. Cmd 0x55 -> rx_err pulse, data_oe never asserted.
//  5. Console stalls high 10 us after 12 symbols of a poll -> rx_err, S_IDLE. A following clean poll is answered correctly.
//  6. reset_n low for 1 cycle mid-reply (bit 30) -> data_oe=0 next edge, busy=0. Next poll fully answered.
//  7. Checker reuses the host receiver: stimulus loops host->responder and compares all 18 decoded fields against the inputs.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared joybus definitions: opcodes, reply sizes, FSM states and framing helpers.
package gc_pkg;

  localparam logic [7:0]  GC_CMD_ID     = 8'h00;
  localparam logic [7:0]  GC_CMD_POLL   = 8'h40;
  localparam logic [7:0]  GC_CMD_ORIGIN = 8'h41;
  localparam logic [7:0]  GC_CMD_RESET  = 8'hFF;

  localparam logic [23:0] GC_ID_WORD    = 24'h090000;

  localparam logic [6:0]  GC_LEN_ID     = 7'd24;
  localparam logic [6:0]  GC_LEN_POLL   = 7'd64;
  localparam logic [6:0]  GC_LEN_ORIGIN = 7'd80;
  localparam int          GC_REPLY_MAX  = 80;

  // Symbols on the wire per command, stop symbol included
  localparam logic [6:0]  GC_SYMS_POLL  = 7'd25;
  localparam logic [6:0]  GC_SYMS_SHORT = 7'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_GAP,
    S_TX,
    S_STOP,
    S_FLUSH
  } gc_state_t;

  function automatic logic gc_opcode_legal(input logic [7:0] op);
    return (op == GC_CMD_ID) || (op == GC_CMD_POLL) ||
           (op == GC_CMD_ORIGIN) || (op == GC_CMD_RESET);
  endfunction

  function automatic logic [6:0] gc_cmd_syms(input logic [7:0] op);
    return (op == GC_CMD_POLL) ? GC_SYMS_POLL : GC_SYMS_SHORT;
  endfunction

  function automatic logic [6:0] gc_reply_len(input logic [7:0] op);
    logic [6:0] len;
    case (op)
      GC_CMD_ID, GC_CMD_RESET: len = GC_LEN_ID;
      GC_CMD_POLL:             len = GC_LEN_POLL;
      GC_CMD_ORIGIN:           len = GC_LEN_ORIGIN;
      default:                 len = 7'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the open-drain joybus line with registered edge pulses.
module gc_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic line,
  output logic fall,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  assign line = sync_reg;

  // Resynchronise the line (idles high) and flag each transition for one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
      fall     <= 1'b0;
      rise     <= 1'b0;
    end else begin
      meta_reg <= data_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      fall     <= prev_reg & ~sync_reg;
      rise     <= ~prev_reg & sync_reg;
    end
  end

endmodule

// File: rtl/gamecube_responder.sv
// Controller end of the joybus link: decodes console commands and replies with pad state.
module gamecube_responder
  import gc_pkg::*;
#(
  parameter int CLKS_PER_US   = 100,
  parameter int RESP_DELAY_US = 4,
  parameter int TIMEOUT_US    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data_in,
  output logic       data_oe,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_x,
  input  logic       btn_y,
  input  logic       btn_start,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_z,
  input  logic       d_up,
  input  logic       d_down,
  input  logic       d_right,
  input  logic       d_left,
  input  logic [7:0] joy_x,
  input  logic [7:0] joy_y,
  input  logic [7:0] c_x,
  input  logic [7:0] c_y,
  input  logic [7:0] trig_l,
  input  logic [7:0] trig_r,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       rumble,
  output logic       busy,
  output logic       rx_err
);

  localparam int BIT_CYC = 4 * CLKS_PER_US;
  localparam int TO_CYC  = TIMEOUT_US * CLKS_PER_US;
  localparam int GAP_CYC = RESP_DELAY_US * CLKS_PER_US;
  localparam int MAX_A   = (BIT_CYC > TO_CYC) ? BIT_CYC : TO_CYC;
  localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] ONE_LOW   = TW'(CLKS_PER_US);
  localparam logic [TW-1:0] ZERO_LOW  = TW'(3 * CLKS_PER_US);
  localparam logic [TW-1:0] SYM_SPLIT = TW'(2 * CLKS_PER_US);

  logic line;
  logic fall;
  logic rise;

  gc_line_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .line    (line),
    .fall    (fall),
    .rise    (rise)
  );

  gc_state_t               state;
  logic [TW-1:0]           timer;
  logic [6:0]              bit_cnt;
  logic [6:0]              rx_shift;
  logic [7:0]              opcode;
  logic [GC_REPLY_MAX-1:0] tx_shift;
  logic [6:0]              tx_len;
  logic [GC_REPLY_MAX-1:0] reply_word;
  logic [63:0]             pad_state;
  logic                    sym;
  logic [TW-1:0]           tx_low;

  assign busy = (state != S_IDLE);

  // A short low pulse is a '1'; the timer holds low time minus one at the rise
  assign sym = (timer < SYM_SPLIT);

  // Stop symbol and '1' bits share the short low time
  assign tx_low = ((state == S_STOP) || tx_shift[GC_REPLY_MAX-1]) ? ONE_LOW : ZERO_LOW;

  assign pad_state = {3'b000, btn_start, btn_y, btn_x, btn_b, btn_a,
                      1'b1, btn_l, btn_r, btn_z, d_up, d_down, d_right, d_left,
                      joy_x, joy_y, c_x, c_y, trig_l, trig_r};

  // Left-aligned reply for the accepted opcode; origin tail is the zero padding
  always_comb begin
    reply_word = '0;
    case (opcode)
      GC_CMD_ID, GC_CMD_RESET:   reply_word = {GC_ID_WORD, 56'h0};
      GC_CMD_POLL, GC_CMD_ORIGIN: reply_word = {pad_state, 16'h0000};
      default:                   reply_word = '0;
    endcase
  end

  // Main protocol FSM: command receive, response gap, bit-serial reply, stop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      opcode    <= '0;
      tx_shift  <= '0;
      tx_len    <= '0;
      data_oe   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      rumble    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rx_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          data_oe <= 1'b0;
          if (fall) begin
            state   <= S_RX;
            timer   <= '0;
            bit_cnt <= '0;
          end
        end
        S_RX: begin
          if (rise) begin
            timer    <= '0;
            bit_cnt  <= bit_cnt + 7'd1;
            rx_shift <= {rx_shift[5:0], sym};
            if (bit_cnt == 7'd7) begin
              opcode <= {rx_shift, sym};
              if (!gc_opcode_legal({rx_shift, sym})) begin
                rx_err <= 1'b1;
                state  <= S_FLUSH;
              end
            end else if (bit_cnt >= 7'd8 && bit_cnt == gc_cmd_syms(opcode) - 7'd1) begin
              // Rise closing the stop symbol: rx_shift[0] is the last data bit
              cmd_valid <= 1'b1;
              cmd_byte  <= opcode;
              if (opcode == GC_CMD_POLL) rumble <= rx_shift[0];
              state     <= S_GAP;
            end
          end else if (fall) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            rx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_FLUSH: begin
          // Leave only after the line has been quietly high for a full timeout
          if (fall || rise || !line) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            state    <= S_TX;
            timer    <= '0;
            bit_cnt  <= '0;
            tx_shift <= reply_word;
            tx_len   <= gc_reply_len(opcode);
            data_oe  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_TX, S_STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (state == S_STOP) begin
              state   <= S_IDLE;
              data_oe <= 1'b0;
            end else begin
              data_oe  <= 1'b1;
              tx_shift <= {tx_shift[GC_REPLY_MAX-2:0], 1'b0};
              bit_cnt  <= bit_cnt + 7'd1;
              if (bit_cnt == tx_len - 7'd1) state <= S_STOP;
            end
          end else begin
            timer   <= timer + TW'(1);
            data_oe <= ((timer + TW'(1)) < tx_low);
          end
        end
        default: begin
          state   <= S_IDLE;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamecube_responder.sv
// Directed bench: the bench plays the console over a modelled open-drain line.
module tb_gamecube_responder;

  localparam int CPU = 10;
  localparam int BIT = 4 * CPU;
  localparam int GAP = 4 * CPU;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic host_low = 1'b0;
  logic data_in;
  logic data_oe;
  logic btn_a, btn_b, btn_x, btn_y, btn_start, btn_l, btn_r, btn_z;
  logic d_up, d_down, d_right, d_left;
  logic [7:0] joy_x, joy_y, c_x, c_y, trig_l, trig_r;
  logic cmd_valid, rumble, busy, rx_err;
  logic [7:0] cmd_byte;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int errors = 0;
  int checks = 0;
  int rel_cyc = 0;
  int cap_n, cap_bad, cap_first;
  logic [79:0] cap_word;

  assign data_in = ~(host_low | data_oe);

  gamecube_responder #(.CLKS_PER_US(CPU), .RESP_DELAY_US(4), .TIMEOUT_US(8)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_oe(data_oe),
    .btn_a(btn_a), .btn_b(btn_b), .btn_x(btn_x), .btn_y(btn_y), .btn_start(btn_start),
    .btn_l(btn_l), .btn_r(btn_r), .btn_z(btn_z),
    .d_up(d_up), .d_down(d_down), .d_right(d_right), .d_left(d_left),
    .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y), .trig_l(trig_l), .trig_r(trig_r),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .rumble(rumble), .busy(busy), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) n_valid++;
    if (rx_err) n_err++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // dig = {start,y,x,b,a,l,r,z,up,down,right,left}; ana = {joy_x,joy_y,c_x,c_y,trig_l,trig_r}
  task automatic set_inputs(input logic [11:0] dig, input logic [47:0] ana);
    {btn_start, btn_y, btn_x, btn_b, btn_a, btn_l, btn_r, btn_z, d_up, d_down, d_right, d_left} = dig;
    {joy_x, joy_y, c_x, c_y, trig_l, trig_r} = ana;
  endtask

  function automatic logic [63:0] pad_model(input logic [11:0] dig, input logic [47:0] ana);
    return {3'b000, dig[11:7], 1'b1, dig[6:0], ana};
  endfunction

  task automatic send_sym(input logic b);
    host_low = 1'b1;
    repeat (b ? CPU : 3 * CPU) @(posedge clk);
    #1;
    host_low = 1'b0;
    repeat (b ? 3 * CPU : CPU) @(posedge clk);
    #1;
  endtask

  task automatic send_syms(input logic [23:0] bits, input int n);
    @(posedge clk);
    #1;
    for (int i = n - 1; i >= 0; i--) send_sym(bits[i]);
  endtask

  task automatic send_stop();
    host_low = 1'b1;
    repeat (CPU) @(posedge clk);
    #1;
    host_low = 1'b0;
    rel_cyc = cyc;
  endtask

  // Console-side receiver: measures each low pulse on data_oe, decodes bits MSB first
  task automatic capture();
    int w[$];
    int run, idle;
    bit seen;
    run = 0; idle = 0; seen = 0;
    cap_word = '0; cap_bad = 0; cap_first = -1;
    for (int c = 0; c < 100 * BIT; c++) begin
      @(negedge clk);
      if (data_oe) begin
        if (!seen) cap_first = cyc;
        seen = 1; run++; idle = 0;
      end else begin
        if (run > 0) begin w.push_back(run); run = 0; end
        idle++;
        if (seen && idle > 2 * BIT) break;
        if (!seen && idle > GAP + 6 * BIT) break;
      end
    end
    cap_n = w.size();
    for (int i = 0; i < cap_n; i++) begin
      if (i == cap_n - 1) begin
        if (w[i] != CPU) cap_bad++;
      end else begin
        if (w[i] != CPU && w[i] != 3 * CPU) cap_bad++;
        if (i < 80) cap_word[79 - i] = (w[i] < 2 * CPU);
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(12'h000, 48'h0);
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({cmd_valid, rx_err, rumble, cmd_byte} !== 11'h0) begin
      errors++; $display("FAIL reset_outputs: got v=%b e=%b r=%b c=%h expected all 0", cmd_valid, rx_err, rumble, cmd_byte);
    end
    $display("reset: data_oe=%b busy=%b cmd_byte=%h", data_oe, busy, cmd_byte);
  endtask

  task automatic test_poll_idle();
    int v0;
    v0 = n_valid;
    set_inputs(12'h000, 48'h0);
    send_syms(24'h400300, 24); send_stop(); capture();
    $display("poll 400300: pulses=%0d word=%h", cap_n, cap_word[79:16]);
    checks++; if (cap_n !== 65) begin errors++; $display("FAIL poll_len: got %0d expected 65", cap_n); end
    checks++; if (cap_word[79:16] !== 64'h0080_0000_0000_0000) begin errors++; $display("FAIL poll_word: got %h expected 0080000000000000", cap_word[79:16]); end
    checks++; if (cap_bad !== 0) begin errors++; $display("FAIL poll_widths: got %0d bad expected 0", cap_bad); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL poll_cmd_valid: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (rumble !== 1'b0 || cmd_byte !== 8'h40) begin errors++; $display("FAIL poll_regs: got rumble=%b cmd=%h expected 0/40", rumble, cmd_byte); end
  endtask

  task automatic test_rumble();
    set_inputs(12'h080, 48'h80_00_00_00_00_FF);
    send_syms(24'h400301, 24); send_stop(); capture();
    $display("poll 400301: pulses=%0d word=%h rumble=%b", cap_n, cap_word[79:16], rumble);
    checks++; if (cap_word[79:16] !== 64'h0180_8000_0000_00FF) begin errors++; $display("FAIL rumble_word: got %h expected 01808000000000FF", cap_word[79:16]); end
    checks++; if (rumble !== 1'b1) begin errors++; $display("FAIL rumble_bit: got %b expected 1", rumble); end
  endtask

  task automatic test_id_timing();
    send_syms(24'h000000, 8); send_stop(); capture();
    $display("id 00: pulses=%0d word=%h latency=%0d", cap_n, cap_word[79:56], cap_first - rel_cyc);
    // two sync flops + edge-pulse register + data_oe register on top of the gap
    checks++; if (cap_first - rel_cyc !== GAP + 4) begin errors++; $display("FAIL id_latency: got %0d expected %0d", cap_first - rel_cyc, GAP + 4); end
    checks++; if (cap_n !== 25) begin errors++; $display("FAIL id_len: got %0d expected 25", cap_n); end
    checks++; if (cap_word[79:56] !== 24'h090000) begin errors++; $display("FAIL id_word: got %h expected 090000", cap_word[79:56]); end
    checks++; if (cmd_byte !== 8'h00) begin errors++; $display("FAIL id_cmd_byte: got %h expected 00", cmd_byte); end
  endtask

  task automatic test_origin_and_bad();
    int e0, v0;
    set_inputs(12'hA5C, 48'h11_22_33_44_55_66);
    send_syms(24'h000041, 8); send_stop(); capture();
    $display("origin 41: pulses=%0d word=%h", cap_n, cap_word);
    checks++; if (cap_n !== 81) begin errors++; $display("FAIL origin_len: got %0d expected 81", cap_n); end
    checks++; if (cap_word !== {pad_model(12'hA5C, 48'h11_22_33_44_55_66), 16'h0000}) begin
      errors++; $display("FAIL origin_word: got %h expected %h", cap_word, {pad_model(12'hA5C, 48'h11_22_33_44_55_66), 16'h0000});
    end
    e0 = n_err; v0 = n_valid;
    send_syms(24'h000055, 8); send_stop(); capture();
    $display("bad 55: pulses=%0d rx_err=%0d", cap_n, n_err - e0);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL bad_rx_err: got %0d expected 1", n_err - e0); end
    checks++; if (cap_n !== 0 || n_valid - v0 !== 0) begin errors++; $display("FAIL bad_no_reply: got pulses=%0d valid=%0d expected 0/0", cap_n, n_valid - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stall();
    int e0;
    e0 = n_err;
    send_syms(24'h000400, 12);
    repeat (10 * CPU) @(posedge clk);
    #1;
    $display("stall after 12 symbols: rx_err=%0d busy=%b", n_err - e0, busy);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL stall_rx_err: got %0d expected 1", n_err - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got busy=%b expected 0", busy); end
    set_inputs(12'h3F0, 48'hDE_AD_BE_EF_01_02);
    send_syms(24'h400300, 24); send_stop(); capture();
    $display("poll after stall: pulses=%0d word=%h", cap_n, cap_word[79:16]);
    checks++; if (cap_word[79:16] !== pad_model(12'h3F0, 48'hDE_AD_BE_EF_01_02) || cap_n !== 65) begin
      errors++; $display("FAIL stall_recover: got %h/%0d expected %h/65", cap_word[79:16], cap_n, pad_model(12'h3F0, 48'hDE_AD_BE_EF_01_02));
    end
  endtask

  task automatic test_reset_mid_reply();
    bit seen;
    seen = 0;
    send_syms(24'h400300, 24); send_stop();
    for (int c = 0; c < GAP + 20; c++) begin
      @(negedge clk);
      if (data_oe) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midreset_start: got no reply expected reply start"); end
    repeat (30 * BIT + 5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    $display("reset at bit 30: data_oe=%b busy=%b cmd_byte=%h", data_oe, busy, cmd_byte);
    checks++; if (data_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_release: got oe=%b busy=%b expected 0/0", data_oe, busy); end
    checks++; if (cmd_byte !== 8'h00) begin errors++; $display("FAIL midreset_cmd_byte: got %h expected 00", cmd_byte); end
    repeat (3 * BIT) @(posedge clk);
    set_inputs(12'h001, 48'h7F_80_01_FE_00_10);
    send_syms(24'h400300, 24); send_stop(); capture();
    $display("poll after reset: pulses=%0d word=%h", cap_n, cap_word[79:16]);
    checks++; if (cap_word[79:16] !== pad_model(12'h001, 48'h7F_80_01_FE_00_10) || cap_n !== 65) begin
      errors++; $display("FAIL midreset_recover: got %h/%0d expected %h/65", cap_word[79:16], cap_n, pad_model(12'h001, 48'h7F_80_01_FE_00_10));
    end
  endtask

  task automatic test_fields();
    logic [11:0] dig_tab [2];
    logic [47:0] ana_tab [2];
    logic [11:0] dig_dec;
    dig_tab[0] = 12'b1_0_1_0_1_0_1_0_1_0_1_0; ana_tab[0] = 48'h12_34_56_78_9A_BC;
    dig_tab[1] = 12'b0_1_0_1_0_1_0_1_0_1_0_1; ana_tab[1] = 48'hC3_3C_A5_5A_0F_F0;
    for (int p = 0; p < 2; p++) begin
      set_inputs(dig_tab[p], ana_tab[p]);
      send_syms(24'h400300, 24); send_stop(); capture();
      $display("field poll %0d: pulses=%0d word=%h", p, cap_n, cap_word[79:16]);
      dig_dec = {cap_word[76:72], cap_word[70:64]};
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (dig_dec[i] !== dig_tab[p][i]) begin errors++; $display("FAIL field_dig%0d_p%0d: got %b expected %b", i, p, dig_dec[i], dig_tab[p][i]); end
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap_word[63 - 8 * i -: 8] !== ana_tab[p][47 - 8 * i -: 8]) begin
          errors++; $display("FAIL field_ana%0d_p%0d: got %h expected %h", i, p, cap_word[63 - 8 * i -: 8], ana_tab[p][47 - 8 * i -: 8]);
        end
      end
      checks++; if (cap_word[79:77] !== 3'b000 || cap_word[71] !== 1'b1) begin errors++; $display("FAIL field_fixed_p%0d: got %b/%b expected 000/1", p, cap_word[79:77], cap_word[71]); end
    end
  endtask

  initial begin
    test_reset();
    test_poll_idle();
    test_rumble();
    test_id_timing();
    test_origin_and_bad();
    test_stall();
    test_reset_mid_reply();
    test_fields();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
